// File: rtl/mux_8to1_d_if.sv
// mux_8to1_d_if: select, data and registered-output bundle for mux_8to1_d.
interface mux_8to1_d_if #(
    parameter int width  = 4,
    parameter int swidth = 3
);
    logic              en;
    logic [swidth-1:0] sel;
    logic [width-1:0]  i0, i1, i2, i3, i4, i5, i6, i7;
    logic [width-1:0]  o;
    logic              o_valid;
    modport master (output en, sel, i0, i1, i2, i3, i4, i5, i6, i7, input o, o_valid);
    modport slave (input en, sel, i0, i1, i2, i3, i4, i5, i6, i7, output o, o_valid);
endinterface

// File: rtl/mux_8to1_d.sv
// mux_8to1_d: registered 8-to-1 word select; one pipeline register, valid pulse per capture.
module mux_8to1_d #(
    parameter int width  = 4,
    parameter int swidth = 3
) (
    input logic         clk,
    input logic         rst_n,
    mux_8to1_d_if.slave bus
);
    if (swidth != 3) begin : g_bad_swidth
        $error("mux_8to1_d: swidth must be 3");
    end
    logic [width-1:0] m0, m1, m2, m3, n0, n1, word;
    logic [width-1:0] o_d, o_q;
    logic             v_d, v_q;
    // balanced tree on sel[0], sel[1], sel[2]; no priority between inputs
    always_comb begin
        m0   = bus.sel[0] ? bus.i1 : bus.i0;
        m1   = bus.sel[0] ? bus.i3 : bus.i2;
        m2   = bus.sel[0] ? bus.i5 : bus.i4;
        m3   = bus.sel[0] ? bus.i7 : bus.i6;
        n0   = bus.sel[1] ? m1 : m0;
        n1   = bus.sel[1] ? m3 : m2;
        word = bus.sel[2] ? n1 : n0;
        o_d  = bus.en ? word : o_q;
        v_d  = bus.en;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
            v_q <= 1'b0;
        end else begin
            o_q <= o_d;
            v_q <= v_d;
        end
    end
    assign bus.o       = o_q;
    assign bus.o_valid = v_q;
endmodule

// File: tb/tb_mux_8to1_d.sv
// tb_mux_8to1_d: random and directed checks of mux_8to1_d (width 4 and 8) against a word-array model.
module tb_mux_8to1_d;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] din [8];
    logic [3:0] e4;
    logic [7:0] e8;
    logic       ev;
    mux_8to1_d_if #(.width(4), .swidth(3)) b4 ();
    mux_8to1_d_if #(.width(8), .swidth(3)) b8 ();
    mux_8to1_d #(.width(4), .swidth(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mux_8to1_d #(.width(8), .swidth(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic apply(input logic e, input logic [2:0] s);
        b4.en = e; b8.en = e; b4.sel = s; b8.sel = s;
        b4.i0 = din[0][3:0]; b4.i1 = din[1][3:0]; b4.i2 = din[2][3:0]; b4.i3 = din[3][3:0];
        b4.i4 = din[4][3:0]; b4.i5 = din[5][3:0]; b4.i6 = din[6][3:0]; b4.i7 = din[7][3:0];
        b8.i0 = din[0]; b8.i1 = din[1]; b8.i2 = din[2]; b8.i3 = din[3];
        b8.i4 = din[4]; b8.i5 = din[5]; b8.i6 = din[6]; b8.i7 = din[7];
    endtask
    task automatic rand_din();
        for (int k = 0; k < 8; k++) din[k] = 8'($urandom);
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".o4"}, 32'(b4.o), 32'(e4));
        chk({tag, ".o8"}, 32'(b8.o), 32'(e8));
        chk({tag, ".v4"}, 32'(b4.o_valid), 32'(ev));
        chk({tag, ".v8"}, 32'(b8.o_valid), 32'(ev));
    endtask
    // one clock: drive at negedge, update model at the rising edge, check just after it
    task automatic step(input string tag, input logic e, input logic [2:0] s);
        @(negedge clk);
        apply(e, s);
        @(posedge clk);
        #1;
        if (e) begin
            e4 = din[s][3:0];
            e8 = din[s];
        end
        ev = e;
        check_all(tag);
    endtask
    initial begin
        logic [2:0] s;
        e4 = '0; e8 = '0; ev = 1'b0;
        rand_din();
        apply(1'b1, 3'(s));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            rand_din();
            apply(1'b1, 3'($urandom));
        end
        check_all("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) din[j] = 8'(10 + (((k % 6) + (j % 4)) % 6));
            step("sweep", 1'b1, 3'(k));
        end
        for (int j = 0; j < 8; j++) din[j] = 8'(j + 2);
        din[0] = 8'd1;
        din[7] = 8'd9;
        step("lat_first", 1'b1, 3'd0);
        chk("lat_first_const", 32'(b4.o), 32'd1);
        @(negedge clk);
        apply(1'b1, 3'd7);
        #2;
        chk("lat_before_edge", 32'(b4.o), 32'd1);
        @(posedge clk);
        #1;
        e4 = 4'd9; e8 = 8'd9; ev = 1'b1;
        chk("lat_after_edge", 32'(b4.o), 32'd9);
        check_all("lat_model");
        s = 3'($urandom);
        rand_din();
        din[s] = 8'd5;
        step("hold_load", 1'b1, s);
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 8; j++) din[j] = ~din[j];
            s = ~s;
            step("hold", 1'b0, s);
            chk("hold_const", 32'(b8.o), 32'd5);
        end
        rand_din();
        din[3] = 8'hA5;
        step("width8", 1'b1, 3'd3);
        chk("width8_const", 32'(b8.o), 32'hA5);
        for (int j = 0; j < 8; j++) din[j] = 8'b0101;
        din[2] = 8'b1010;
        step("bit_indep", 1'b1, 3'd2);
        chk("bit_indep_const", 32'(b4.o), 32'b1010);
        for (int c = 0; c < 200; c++) begin
            rand_din();
            step("random", 1'(($urandom % 4) != 0), 3'($urandom));
        end
        rand_din();
        step("pre_reset", 1'b1, 3'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        e4 = '0; e8 = '0; ev = 1'b0;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rand_din();
        step("post_reset", 1'b1, 3'($urandom));
        for (int c = 0; c < 20; c++) begin
            rand_din();
            step("random2", 1'($urandom), 3'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
